// File: rtl/attn_token_loader_pkg.sv
// attn_pkg: shared state encoding, default geometry and counter width helper for the token loader
package attn_pkg;

    typedef enum logic {
        FILL    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_TOKEN_DIM  = 4;
    localparam int DEF_TOKEN_NUM  = 8;

    // a single-token frame still needs a one-bit counter to keep ports legal
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/attn_token_loader_if.sv
// attn_token_loader_if: upstream token-row stream (valid/ready handshake plus Q/K/V row payload)
interface attn_token_loader_if
    import attn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TOKEN_DIM  = DEF_TOKEN_DIM
);
    logic                            in_valid;
    logic                            in_ready;
    logic                            in_first;
    logic [DATA_WIDTH*TOKEN_DIM-1:0] in_q;
    logic [DATA_WIDTH*TOKEN_DIM-1:0] in_k;
    logic [DATA_WIDTH*TOKEN_DIM-1:0] in_v;

    modport master (output in_valid, in_first, in_q, in_k, in_v, input in_ready);
    modport slave  (input in_valid, in_first, in_q, in_k, in_v, output in_ready);

endinterface

// File: rtl/attn_token_loader_row_bank.sv
// attn_row_bank: TOKEN_NUM registered rows, one row written per cycle at the given address
module attn_row_bank #(
    parameter int ROW_W     = 64,
    parameter int TOKEN_NUM = 8,
    parameter int ADDR_W    = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [ROW_W-1:0]           din,
    output logic [ROW_W*TOKEN_NUM-1:0] rows
);

    for (genvar g = 0; g < TOKEN_NUM; g++) begin : g_row
        logic [ROW_W-1:0] r;
        // each slot only changes when addressed; other slots keep the previous frame
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r <= '0;
            else if (we && addr == ADDR_W'(g)) r <= din;
        end
        assign rows[g*ROW_W +: ROW_W] = r;
    end

endmodule

// File: rtl/attn_token_loader.sv
// attn_token_loader: collects token rows into full Q/K/V frames and presents each frame until consumed
module attn_token_loader
    import attn_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TOKEN_DIM  = DEF_TOKEN_DIM,
    parameter int TOKEN_NUM  = DEF_TOKEN_NUM
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    attn_token_loader_if.slave                        in_row,
    output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] Q,
    output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] K,
    output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] V,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      frame_err
);

    localparam int RW = DATA_WIDTH * TOKEN_DIM;
    localparam int CW = cnt_w(TOKEN_NUM);

    state_t          state, state_nx;
    logic [CW-1:0]   row_cnt, row_cnt_nx, wr_addr;
    logic            xfer, restart, last, frame_err_nx;

    assign in_row.in_ready = (state == FILL);
    assign out_valid       = (state == PRESENT);

    // next-state logic: a restart takes priority over completing the frame
    always_comb begin
        xfer         = in_row.in_valid && state == FILL;
        restart      = xfer && in_row.in_first && row_cnt != '0;
        last         = xfer && !restart && row_cnt == CW'(TOKEN_NUM - 1);
        wr_addr      = restart ? '0 : row_cnt;
        row_cnt_nx   = restart ? CW'(1) : last ? '0 : xfer ? row_cnt + 1'b1 : row_cnt;
        state_nx     = (state == FILL) ? (last ? PRESENT : FILL) : (out_ready ? FILL : PRESENT);
        frame_err_nx = frame_err | restart;
    end

    // state, row counter and sticky error register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            row_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            row_cnt   <= row_cnt_nx;
            frame_err <= frame_err_nx;
        end
    end

    attn_row_bank #(.ROW_W(RW), .TOKEN_NUM(TOKEN_NUM), .ADDR_W(CW)) u_q (
        .clk(clk), .rst_n(rst_n), .we(xfer), .addr(wr_addr), .din(in_row.in_q), .rows(Q)
    );

    attn_row_bank #(.ROW_W(RW), .TOKEN_NUM(TOKEN_NUM), .ADDR_W(CW)) u_k (
        .clk(clk), .rst_n(rst_n), .we(xfer), .addr(wr_addr), .din(in_row.in_k), .rows(K)
    );

    attn_row_bank #(.ROW_W(RW), .TOKEN_NUM(TOKEN_NUM), .ADDR_W(CW)) u_v (
        .clk(clk), .rst_n(rst_n), .we(xfer), .addr(wr_addr), .din(in_row.in_v), .rows(V)
    );

endmodule

// File: tb/tb_attn_token_loader.sv
// tb_attn_token_loader: directed scenario tests for the token loader (8-token and 1-token builds)
module tb_attn_token_loader;

    logic         clk;
    logic         rst_n;
    logic [511:0] q, k, v;
    logic         out_valid, out_ready, frame_err;
    logic [63:0]  q1, k1, v1;
    logic         out_valid1, out_ready1, frame_err1;
    logic [511:0] eq, ek, ev;
    int           passed;
    int           total;

    attn_token_loader_if #(.DATA_WIDTH(16), .TOKEN_DIM(4)) rif ();
    attn_token_loader_if #(.DATA_WIDTH(16), .TOKEN_DIM(4)) rif1 ();

    attn_token_loader #(.DATA_WIDTH(16), .TOKEN_DIM(4), .TOKEN_NUM(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_row(rif), .Q(q), .K(k), .V(v),
        .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err)
    );

    attn_token_loader #(.DATA_WIDTH(16), .TOKEN_DIM(4), .TOKEN_NUM(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_row(rif1), .Q(q1), .K(k1), .V(v1),
        .out_valid(out_valid1), .out_ready(out_ready1), .frame_err(frame_err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // drive one row (or an idle cycle) at a falling edge and advance to the next falling edge
    task automatic push(input logic vld, input logic f, input logic [15:0] b);
        rif.in_valid = vld;
        rif.in_first = f;
        rif.in_q = {4{b}};
        rif.in_k = {4{b + 16'h0001}};
        rif.in_v = {4{b + 16'h0002}};
        @(negedge clk);
    endtask

    task automatic idle();
        rif.in_valid = 1'b0;
        rif.in_first = 1'b0;
    endtask

    task automatic exp_row(input int i, input logic [15:0] b);
        eq[64*i +: 64] = {4{b}};
        ek[64*i +: 64] = {4{b + 16'h0001}};
        ev[64*i +: 64] = {4{b + 16'h0002}};
    endtask

    task automatic release_frame();
        idle();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (rif.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", rif.in_ready); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else passed++;
        total++; if ({q, k, v} !== '0) $display("FAIL reset_qkv: got %h want 0", q); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            push(1'b1, i == 0, 16'(16'h0100 * (i + 1)));
            exp_row(i, 16'(16'h0100 * (i + 1)));
            if (i == 6) begin
                total++; if (out_valid !== 1'b0) $display("FAIL fill_early_valid: got %b want 0", out_valid); else passed++;
            end
        end
        idle();
        total++; if (out_valid !== 1'b1) $display("FAIL fill_out_valid: got %b want 1", out_valid); else passed++;
        total++; if (rif.in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b want 0", rif.in_ready); else passed++;
        total++; if (q[16*31 +: 16] !== 16'h0800) $display("FAIL fill_q_t7e3: got %h want 0800", q[16*31 +: 16]); else passed++;
        total++; if ({q, k, v} !== {eq, ek, ev}) $display("FAIL fill_frame: got %h want %h", q, eq); else passed++;
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            push(1'b1, 1'b0, 16'hDEAD);
            total++; if (rif.in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL hold_handshake: got ready=%b valid=%b want 0/1", rif.in_ready, out_valid); else passed++;
            total++; if ({q, k, v} !== {eq, ek, ev}) $display("FAIL hold_stable: got %h want %h", q, eq); else passed++;
        end
        release_frame();
        total++; if (out_valid !== 1'b0 || rif.in_ready !== 1'b1) $display("FAIL hold_return: got valid=%b ready=%b want 0/1", out_valid, rif.in_ready); else passed++;
        total++; if ({q, k, v} !== {eq, ek, ev}) $display("FAIL hold_after_release: got %h want %h", q, eq); else passed++;
    endtask

    task automatic test_restart();
        for (int i = 0; i < 3; i++) push(1'b1, i == 0, 16'(16'hA001 + i));
        push(1'b1, 1'b1, 16'h00FF);
        idle();
        total++; if (q[63:0] !== {4{16'h00FF}}) $display("FAIL restart_slot0: got %h want 00ff x4", q[63:0]); else passed++;
        total++; if (q[127:64] !== {4{16'hA002}}) $display("FAIL restart_slot1_kept: got %h want a002 x4", q[127:64]); else passed++;
        total++; if (frame_err !== 1'b1) $display("FAIL restart_frame_err: got %b want 1", frame_err); else passed++;
        exp_row(0, 16'h00FF);
        for (int i = 1; i < 8; i++) begin
            push(1'b1, 1'b0, 16'(16'hB000 + i));
            exp_row(i, 16'(16'hB000 + i));
            if (i == 6) begin
                total++; if (out_valid !== 1'b0) $display("FAIL restart_early_valid: got %b want 0", out_valid); else passed++;
            end
        end
        idle();
        total++; if (out_valid !== 1'b1) $display("FAIL restart_out_valid: got %b want 1", out_valid); else passed++;
        total++; if ({q, k, v} !== {eq, ek, ev}) $display("FAIL restart_frame: got %h want %h", q, eq); else passed++;
        release_frame();
        total++; if (frame_err !== 1'b1) $display("FAIL restart_sticky: got %b want 1", frame_err); else passed++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) push(1'b1, 1'b0, 16'(16'hC001 + i));
        idle();
        rst_n = 1'b0;
        #1;
        total++; if ({q, k, v} !== '0) $display("FAIL rstmid_qkv: got %h want 0", q); else passed++;
        total++; if (frame_err !== 1'b0 || out_valid !== 1'b0) $display("FAIL rstmid_flags: got err=%b valid=%b want 0/0", frame_err, out_valid); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            push(1'b1, 1'b0, 16'(16'h0D00 + i));
            exp_row(i, 16'(16'h0D00 + i));
        end
        idle();
        total++; if (out_valid !== 1'b1 || frame_err !== 1'b0) $display("FAIL rstmid_clean: got valid=%b err=%b want 1/0", out_valid, frame_err); else passed++;
        total++; if ({q, k, v} !== {eq, ek, ev}) $display("FAIL rstmid_frame: got %h want %h", q, eq); else passed++;
        release_frame();
    endtask

    task automatic test_toggle();
        for (int c = 0; c < 16; c++) begin
            push(c % 2 == 0, 1'b0, 16'(16'hE000 + c / 2));
            if (c % 2 == 0) exp_row(c / 2, 16'(16'hE000 + c / 2));
            total++; if (out_valid !== (c >= 14)) $display("FAIL toggle_valid_c%0d: got %b want %b", c, out_valid, c >= 14); else passed++;
        end
        idle();
        total++; if ({q, k, v} !== {eq, ek, ev}) $display("FAIL toggle_frame: got %h want %h", q, eq); else passed++;
        release_frame();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(1'b1, i == 0, 16'(16'h1000 + i));
            exp_row(i, 16'(16'h1000 + i));
        end
        total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid1: got %b want 1", out_valid); else passed++;
        total++; if ({q, k, v} !== {eq, ek, ev}) $display("FAIL b2b_frame1: got %h want %h", q, eq); else passed++;
        push(1'b1, 1'b1, 16'hFFFF);
        total++; if (rif.in_ready !== 1'b1 || q[63:0] !== {4{16'h1000}}) $display("FAIL b2b_ignored: got ready=%b slot0=%h want 1/1000 x4", rif.in_ready, q[63:0]); else passed++;
        for (int i = 0; i < 8; i++) begin
            push(1'b1, i == 0, 16'(16'h2000 + i));
            exp_row(i, 16'(16'h2000 + i));
        end
        idle();
        total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid2: got %b want 1", out_valid); else passed++;
        total++; if ({q, k, v} !== {eq, ek, ev}) $display("FAIL b2b_frame2: got %h want %h", q, eq); else passed++;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_release: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_single_token();
        rif1.in_valid = 1'b1;
        rif1.in_q = {4{16'h1234}};
        rif1.in_k = {4{16'h4321}};
        rif1.in_v = {4{16'h8001}};
        @(negedge clk);
        rif1.in_valid = 1'b0;
        total++; if (out_valid1 !== 1'b1 || {q1, k1, v1} !== {{4{16'h1234}}, {4{16'h4321}}, {4{16'h8001}}}) $display("FAIL single_first: got valid=%b q=%h want 1/1234 x4", out_valid1, q1); else passed++;
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        total++; if (out_valid1 !== 1'b0 || rif1.in_ready !== 1'b1) $display("FAIL single_release: got valid=%b ready=%b want 0/1", out_valid1, rif1.in_ready); else passed++;
        rif1.in_valid = 1'b1;
        rif1.in_q = {4{16'h5678}};
        @(negedge clk);
        rif1.in_valid = 1'b0;
        total++; if (out_valid1 !== 1'b1 || q1 !== {4{16'h5678}}) $display("FAIL single_second: got valid=%b q=%h want 1/5678 x4", out_valid1, q1); else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        eq = '0;
        ek = '0;
        ev = '0;
        out_ready = 1'b0;
        out_ready1 = 1'b0;
        rif.in_valid = 1'b0;
        rif.in_first = 1'b0;
        rif.in_q = '0;
        rif.in_k = '0;
        rif.in_v = '0;
        rif1.in_valid = 1'b0;
        rif1.in_first = 1'b0;
        rif1.in_q = '0;
        rif1.in_k = '0;
        rif1.in_v = '0;
        test_reset();
        test_fill();
        test_hold();
        test_restart();
        test_reset_mid();
        test_toggle();
        test_back_to_back();
        test_single_token();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
